// File: rtl/reg_lock_scheduler.sv
// reg_lock_scheduler: register lock table, memory-busy flag and round-robin issue grant.
// One requester per cycle is granted against registered lock state; a blocking grant locks the whole machine.
module reg_lock_scheduler #(
    parameter int NR = 64,
    parameter int NP = 4,
    localparam int RW = $clog2(NR),
    localparam int PW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NP-1:0]          pl_valid_i,
    input  logic [NP-1:0]          blocking_i,
    input  logic [NP-1:0][RW-1:0]  rd_i,
    input  logic [NP-1:0][NR-1:0]  reg_req_i,
    input  logic [NP-1:0]          mem_op_i,
    input  logic                   wb_valid_i,
    input  logic [RW-1:0]          wb_rd_i,
    input  logic                   mem_done_i,
    input  logic                   blk_done_i,
    output logic [NP-1:0]          gnt_o,
    output logic [PW-1:0]          gnt_idx_o,
    output logic [NR-1:0]          locks_o,
    output logic                   mem_busy_o,
    output logic                   blocked_o
);
    typedef enum logic {IDLE, BLOCKED} state_t;
    state_t        r_state;
    logic [NR-1:0] r_locks;
    logic          r_mem_busy;
    logic [PW-1:0] r_rr;
    logic [NP-1:0] w_elig;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_cand;
    logic [PW-1:0] w_rr_nxt;
    logic          w_found;
    logic          w_blk_gnt;
    logic          w_mem_gnt;
    logic [NR-1:0] w_locks_nxt;
    always_comb begin
        w_elig = '0;
        for (int p = 0; p < NP; p++)
            w_elig[p] = r_state == IDLE && pl_valid_i[p]
                && (reg_req_i[p] & r_locks) == '0
                && (rd_i[p] == '0 || !r_locks[rd_i[p]])
                && !(mem_op_i[p] && r_mem_busy)
                && (!blocking_i[p] || (r_locks == '0 && !r_mem_busy));
    end
    // Round-robin search starting at r_rr, ascending with wrap.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < NP; i++) begin
            w_cand = PW'((int'(r_rr) + i) % NP);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end
    assign w_rr_nxt  = PW'((int'(w_idx) + 1) % NP);
    assign w_blk_gnt = w_found && blocking_i[w_idx];
    assign w_mem_gnt = w_found && mem_op_i[w_idx] && !blocking_i[w_idx];
    // Release first, then the grant's set, so a same-cycle set of the same bit wins.
    always_comb begin
        w_locks_nxt = r_locks;
        if (wb_valid_i) w_locks_nxt[wb_rd_i] = 1'b0;
        if (w_found && rd_i[w_idx] != '0) w_locks_nxt[rd_i[w_idx]] = 1'b1;
        w_locks_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_locks    <= '0;
            r_mem_busy <= 1'b0;
            r_rr       <= '0;
        end else if (r_state == BLOCKED) begin
            if (blk_done_i) begin
                r_state <= IDLE;
                r_locks <= '0;
            end
        end else begin
            r_locks    <= w_blk_gnt ? ~NR'(1) : w_locks_nxt;
            r_mem_busy <= w_mem_gnt | (r_mem_busy & ~mem_done_i);
            if (w_blk_gnt) r_state <= BLOCKED;
            if (w_found) r_rr <= w_rr_nxt;
        end
    end
    assign gnt_o      = w_found ? NP'(1) << w_idx : '0;
    assign gnt_idx_o  = w_idx;
    assign locks_o    = r_locks;
    assign mem_busy_o = r_mem_busy;
    assign blocked_o  = r_state == BLOCKED;
endmodule

// File: doc/reg_lock_scheduler.md
Name: reg_lock_scheduler

Overview:
Stateful issue scheduler that owns the architectural register lock table and the memory-busy flag. It performs the lock/grant check for NP pipeline issue requesters against registered lock state. It picks one eligible requester per cycle by round-robin, and updates locks on grant and on writeback release. It sits between the decode/issue slots and the execution units, and feeds locks_o back to decode.

Parameters:
NR, 64, number of architectural registers (maverickOne_pkg::NUM_REGS); register 0 is hardwired zero and never locked
NP, 4, number of issue requesters

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_i  input  1  synchronous active-high reset
pl_valid_i  input  NP  per-requester instruction valid; requester holds all its fields stable until granted
blocking_i  input  NP  per-requester blocking instruction (fence/CSR): needs exclusive machine
rd_i  input  NP x $clog2(NR)  per-requester destination register index
reg_req_i  input  NP x NR  per-requester source register requirement mask
mem_op_i  input  NP  per-requester memory operation flag
wb_valid_i  input  1  writeback valid; releases lock of wb_rd_i
wb_rd_i  input  $clog2(NR)  writeback destination index
mem_done_i  input  1  memory unit finished; clears memory busy
blk_done_i  input  1  blocking instruction retired; leaves BLOCKED state
gnt_o  output  NP  one-hot grant (all zero if none)
gnt_idx_o  output  $clog2(NP)  index of granted requester, 0 when none
locks_o  output  NR  current lock table (registered)
mem_busy_o  output  1  memory busy flag (registered)
blocked_o  output  1  high in BLOCKED state

Behaviour:
- Reset: locks_q=0, mem_busy_q=0, state=IDLE, rr_ptr=0. Outputs locks_o=0, mem_busy_o=0, blocked_o=0, gnt_o=0, gnt_idx_o=0.
- locks_o, mem_busy_o and blocked_o are direct register outputs. gnt_o/gnt_idx_o are combinational from registered state plus current requests (zero-cycle issue).
- Eligibility of requester p (IDLE only):
  - pl_valid_i[p]
  - (reg_req_i[p] & locks_q)==0
  - rd_i[p]==0 or locks_q[rd_i[p]]==0
  - not (mem_op_i[p] and mem_busy_q)
  - if blocking_i[p]: locks_q==0 and mem_busy_q==0
- Arbitration: round-robin. Search starts at rr_ptr, ascending with wrap. On grant of p, rr_ptr <= (p+1) mod NP. No grant means rr_ptr is unchanged.
- States: IDLE, BLOCKED.
  - IDLE -> BLOCKED on grant of a blocking requester. Next-cycle locks_q = all ones except bit 0.
  - BLOCKED: gnt_o=0. wb_valid_i and mem_done_i are ignored.
  - BLOCKED -> IDLE on blk_done_i: locks_q cleared to 0.
  - blk_done_i in IDLE is ignored.
- Non-blocking grant effects (next cycle):
  - locks_q[rd] <= 1 if rd!=0.
  - mem_busy_q <= 1 if mem_op.
- Release (IDLE): wb_valid_i with wb_rd_i!=0 clears locks_q[wb_rd_i]. wb_rd_i==0 has no effect.
- Simultaneous events:
  - Grant setting bit k and release of bit k in the same cycle: set wins, lock stays 1.
  - mem_done_i with a memory grant in the same cycle: mem_busy_q stays 1.
  - Release is not visible to eligibility until the next cycle, so minimum wb-to-dependent-grant latency is 1 cycle.
- Bit 0 of locks_q is forced 0 at all times.
- Reset mid-operation (any state) restores reset values on the next edge; outstanding locks are discarded.

Test Plan:
- Reset, then no requests -> locks_o=0, mem_busy_o=0, gnt_o=0000, blocked_o=0.
- Requesters 0,1,2 valid, no sources, rd=5,6,7, held over 3 cycles -> grants 0,1,2 in successive cycles; locks_o bits 5,6,7 set one cycle after each respective grant.
- Requester 1 with reg_req bit 5 while locks_o[5]=1 -> no grant. wb_valid_i=1, wb_rd_i=5 -> locks_o[5]=0 next cycle, gnt_o=0010 in that same cycle. Repeat with a same-cycle grant to rd=5 -> locks_o[5] remains 1.
- mem_op requester granted -> mem_busy_o=1. A second mem_op requester is blocked until mem_done_i, then granted the cycle after.
- Blocking request with locks_o[3]=1 -> no grant. After release of bit 3 -> grant, blocked_o=1, locks_o=all-ones except bit 0. No grants occur until blk_done_i, after which locks_o=0.
- rst_i asserted during BLOCKED with locks set -> next cycle all outputs at reset values, rr_ptr=0, so requester 0 wins the first contention.
